thermo_mask_pipe: RTL

THERMO_MASK_PIPE -- requirements
Module: thermo_mask_pipe

---
 rtl/thermo_mask_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/thermo_mask_pipe.sv
// Two-stage elastic pipeline turning a boundary index into a thermometer mask.
// Stage 1 captures the request, stage 2 holds the mask, popcount and out-of-range flag.
module thermo_mask_pipe #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned LOG_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOG_W-1:0] enc,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] thermo,
    output logic [LOG_W:0]   count,
    output logic             oor
);

    localparam int unsigned CW = LOG_W + 1;
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    localparam logic [1:0] MODE_LT = 2'b00;
    localparam logic [1:0] MODE_LE = 2'b01;
    localparam logic [1:0] MODE_GE = 2'b10;
    localparam logic [1:0] MODE_GT = 2'b11;

    logic             r_s1_valid;
    logic [LOG_W-1:0] r_s1_enc;
    logic [1:0]       r_s1_mode;
    logic             r_s1_oor;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_thermo;
    logic [CW-1:0]    r_count;
    logic             r_oor;

    logic             w_s2_ready;
    logic             w_s2_load;
    logic             w_in_fire;
    logic             w_in_oor;
    logic [CW-1:0]    w_enc_x;
    logic [CW-1:0]    w_enc_p1;
    logic [CW-1:0]    w_lo;
    logic [CW-1:0]    w_lo1;
    logic [CW-1:0]    w_count;
    logic [WIDTH-1:0] w_thermo;

    // Handshake: a stage accepts when empty or when its consumer drains this cycle.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s2_load  = r_s1_valid && w_s2_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_in_oor   = {1'b0, enc} >= WIDTH_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_enc   <= '0;
            r_s1_mode  <= MODE_LT;
            r_s1_oor   <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_s1_enc  <= enc;
                r_s1_mode <= mode;
                r_s1_oor  <= w_in_oor;
            end
        end
    end

    // enc+1 is formed one bit wider so the all-ones index does not wrap.
    assign w_enc_x  = {1'b0, r_s1_enc};
    assign w_enc_p1 = w_enc_x + CW'(1);
    assign w_lo     = (w_enc_x  < WIDTH_C) ? w_enc_x  : WIDTH_C;
    assign w_lo1    = (w_enc_p1 < WIDTH_C) ? w_enc_p1 : WIDTH_C;

    always_comb begin
        w_count = '0;
        case (r_s1_mode)
            MODE_LT: w_count = w_lo;
            MODE_LE: w_count = w_lo1;
            MODE_GE: w_count = WIDTH_C - w_lo;
            default: w_count = WIDTH_C - w_lo1;
        endcase
    end

    always_comb begin
        w_thermo = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case (r_s1_mode)
                MODE_LT: w_thermo[i] = CW'(i) <  w_enc_x;
                MODE_LE: w_thermo[i] = CW'(i) <= w_enc_x;
                MODE_GE: w_thermo[i] = CW'(i) >= w_enc_x;
                default: w_thermo[i] = CW'(i) >  w_enc_x;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_thermo   <= '0;
            r_count    <= '0;
            r_oor      <= 1'b0;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_thermo <= w_thermo;
                r_count  <= w_count;
                r_oor    <= r_s1_oor;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign thermo    = r_thermo;
    assign count     = r_count;
    assign oor       = r_oor;

endmodule
